// File: rtl/prefetch_slice_arbiter.sv
// prefetch_slice_arbiter
//   Shares one AXI read master port (AR + R) toward DDR between NUM_SLICES
//   prefetcher slice controllers.
//   - AR: round-robin grant among requesting slices. One request is held on
//     the registered master AR bus at a time.
//   - R : each returning burst is steered to the lowest slice whose learned
//     context ID matches the burst ID. Ownership is locked until the last
//     beat. Bursts with no matching slice are sunk (dropped).
//
// Ports
//   clk, resetN              clock, asynchronous active-low reset
//   en                       global enable; low = hold all state, no handshakes
//   sl_ar_valid/ready/addr/len/id   per-slice AR requests (flattened payloads)
//   sl_ctx_valid/sl_ctx_id   per-slice context used for R routing
//   sl_r_valid/sl_r_ready    per-slice R handshake
//   m_ar_valid/ready/addr/len/id    master AR channel (registered outputs)
//   m_r_valid/ready/id/last  master R channel
//   r_owner, r_busy          current R owner index / R channel locked
//   drop_cnt                 saturating count of sunk R beats
//
// Configuration
//   PR_ARB_DROP_CNT_EN  when defined, drop_cnt counts sunk beats; otherwise
//                       it is tied to 0 and no counter is built.

module prefetch_slice_arbiter #(
  parameter int  NUM_SLICES      = 4,
  parameter int  ADDR_BITS       = 64,
  parameter int  BURST_LEN_WIDTH = 8,
  parameter int  TID_WIDTH       = 8,
  parameter int  DROP_CNT_WIDTH  = 16,
  localparam int IDX_W           = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic                                  clk,
  input  logic                                  resetN,
  input  logic                                  en,
  input  logic [NUM_SLICES-1:0]                 sl_ar_valid,
  output logic [NUM_SLICES-1:0]                 sl_ar_ready,
  input  logic [NUM_SLICES*ADDR_BITS-1:0]       sl_ar_addr,
  input  logic [NUM_SLICES*BURST_LEN_WIDTH-1:0] sl_ar_len,
  input  logic [NUM_SLICES*TID_WIDTH-1:0]       sl_ar_id,
  input  logic [NUM_SLICES-1:0]                 sl_ctx_valid,
  input  logic [NUM_SLICES*TID_WIDTH-1:0]       sl_ctx_id,
  output logic [NUM_SLICES-1:0]                 sl_r_valid,
  input  logic [NUM_SLICES-1:0]                 sl_r_ready,
  output logic                                  m_ar_valid,
  input  logic                                  m_ar_ready,
  output logic [ADDR_BITS-1:0]                  m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]            m_ar_len,
  output logic [TID_WIDTH-1:0]                  m_ar_id,
  input  logic                                  m_r_valid,
  output logic                                  m_r_ready,
  input  logic [TID_WIDTH-1:0]                  m_r_id,
  input  logic                                  m_r_last,
  output logic [IDX_W-1:0]                      r_owner,
  output logic                                  r_busy,
  output logic [DROP_CNT_WIDTH-1:0]             drop_cnt
);

  typedef enum logic       {AR_IDLE, AR_ISSUE}        ar_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ROUTE, R_DROP}  r_state_t;

  ar_state_t        ar_state, ar_state_nx;
  r_state_t         r_state, r_state_nx;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nx, ar_win;
  logic [IDX_W-1:0] r_match, r_owner_nx;
  logic             ar_hit, ar_grant, r_hit, r_busy_nx, r_hs, m_ar_valid_q;
  logic             live;

  // Handshake-qualifying term: nothing toward either side while in reset or
  // disabled.
  assign live = resetN & en;

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    logic [IDX_W-1:0] cand;
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned (which would infer a latch).
    cand   = '0;
    ar_hit = 1'b0;
    ar_win = '0;
    for (int k = 0; k < NUM_SLICES; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_SLICES);
      if (!ar_hit && sl_ar_valid[cand]) begin
        ar_hit = 1'b1;
        ar_win = cand;
      end
    end
  end

  assign rr_ptr_nx = (ar_win == IDX_W'(NUM_SLICES - 1)) ? '0 : ar_win + IDX_W'(1);

  // Lowest slice whose valid context ID matches the returning burst ID.
  always_comb begin
    r_hit   = 1'b0;
    r_match = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (!r_hit && sl_ctx_valid[i] && (sl_ctx_id[i*TID_WIDTH +: TID_WIDTH] == m_r_id)) begin
        r_hit   = 1'b1;
        r_match = IDX_W'(i);
      end
    end
  end

  // AR next-state and slice grant.
  always_comb begin
    ar_state_nx = ar_state;
    ar_grant    = 1'b0;
    sl_ar_ready = '0;
    case (ar_state)
      AR_IDLE: begin
        if (live && ar_hit) begin
          ar_grant            = 1'b1;
          sl_ar_ready[ar_win] = 1'b1;
          ar_state_nx         = AR_ISSUE;
        end
      end
      AR_ISSUE: begin
        if (live && m_ar_valid_q && m_ar_ready) ar_state_nx = AR_IDLE;
      end
      default: ar_state_nx = AR_IDLE;
    endcase
  end

  // R next-state and steering. The first beat of a burst is only inspected in
  // R_IDLE; it is consumed once ownership is registered.
  always_comb begin
    r_state_nx = r_state;
    r_owner_nx = r_owner;
    r_busy_nx  = r_busy;
    sl_r_valid = '0;
    m_r_ready  = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (live && m_r_valid) begin
          r_busy_nx = 1'b1;
          if (r_hit) begin
            r_owner_nx = r_match;
            r_state_nx = R_ROUTE;
          end else begin
            r_state_nx = R_DROP;
          end
        end
      end
      R_ROUTE: begin
        // Context changes are ignored here: the owner keeps the whole burst.
        if (live) begin
          sl_r_valid[r_owner] = m_r_valid;
          m_r_ready           = sl_r_ready[r_owner];
        end
        if (m_r_valid && m_r_ready && m_r_last) begin
          r_state_nx = R_IDLE;
          r_busy_nx  = 1'b0;
        end
      end
      R_DROP: begin
        m_r_ready = live;
        if (m_r_valid && m_r_ready && m_r_last) begin
          r_state_nx = R_IDLE;
          r_busy_nx  = 1'b0;
        end
      end
      default: begin
        r_state_nx = R_IDLE;
        r_busy_nx  = 1'b0;
      end
    endcase
  end

  assign r_hs = m_r_valid & m_r_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      // NOTE: the AR payload registers are reset too; they are few and the
      // reset value is observable on the master bus.
      ar_state     <= AR_IDLE;
      r_state      <= R_IDLE;
      rr_ptr       <= '0;
      m_ar_valid_q <= 1'b0;
      m_ar_addr    <= '0;
      m_ar_len     <= '0;
      m_ar_id      <= '0;
      r_owner      <= '0;
      r_busy       <= 1'b0;
    end else if (en) begin
      ar_state <= ar_state_nx;
      r_state  <= r_state_nx;
      r_owner  <= r_owner_nx;
      r_busy   <= r_busy_nx;
      if (ar_grant) begin
        rr_ptr       <= rr_ptr_nx;
        m_ar_valid_q <= 1'b1;
        m_ar_addr    <= sl_ar_addr[ar_win*ADDR_BITS +: ADDR_BITS];
        m_ar_len     <= sl_ar_len[ar_win*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
        m_ar_id      <= sl_ar_id[ar_win*TID_WIDTH +: TID_WIDTH];
      end else if (ar_state == AR_ISSUE && m_ar_ready) begin
        m_ar_valid_q <= 1'b0;
      end
    end
  end

  // Masked by en so a stalled arbiter never presents a request the DDR side
  // could accept while our state is frozen.
  assign m_ar_valid = m_ar_valid_q & en;

`ifdef PR_ARB_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drop_cnt_q <= '0;
    end else if (en && r_state == R_DROP && r_hs && !(&drop_cnt_q)) begin
      drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_prefetch_slice_arbiter.sv
// Self-checking bench for prefetch_slice_arbiter.
// AR: a reference model computes the expected round-robin winner, pushes the
// winner's payload when the slice handshake is driven, and pops/compares it
// when the master AR handshake occurs. R: each burst pushes the expected
// destination per beat; beats are popped/compared as they are accepted.
module tb_prefetch_slice_arbiter;
  localparam int N  = 4;
  localparam int AW = 64;
  localparam int LW = 8;
  localparam int TW = 8;
  localparam int DW = 16;
  localparam int IW = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [TW-1:0] id;
  } ar_t;

  logic              clk = 1'b0;
  logic              resetN, en;
  logic [N-1:0]      sl_ar_valid, sl_ar_ready, sl_ctx_valid, sl_r_valid, sl_r_ready;
  logic [N*AW-1:0]   sl_ar_addr;
  logic [N*LW-1:0]   sl_ar_len;
  logic [N*TW-1:0]   sl_ar_id, sl_ctx_id;
  logic              m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last, r_busy;
  logic [AW-1:0]     m_ar_addr;
  logic [LW-1:0]     m_ar_len;
  logic [TW-1:0]     m_ar_id, m_r_id;
  logic [IW-1:0]     r_owner;
  logic [DW-1:0]     drop_cnt;

  logic [AW-1:0] addr_a [N];
  logic [LW-1:0] len_a  [N];
  logic [TW-1:0] id_a   [N];
  logic [TW-1:0] ctx_a  [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign sl_ar_addr[g*AW +: AW] = addr_a[g];
    assign sl_ar_len[g*LW +: LW]  = len_a[g];
    assign sl_ar_id[g*TW +: TW]   = id_a[g];
    assign sl_ctx_id[g*TW +: TW]  = ctx_a[g];
  end

  prefetch_slice_arbiter #(
    .NUM_SLICES(N), .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(TW), .DROP_CNT_WIDTH(DW)
  ) dut (
    .clk(clk), .resetN(resetN), .en(en),
    .sl_ar_valid(sl_ar_valid), .sl_ar_ready(sl_ar_ready), .sl_ar_addr(sl_ar_addr),
    .sl_ar_len(sl_ar_len), .sl_ar_id(sl_ar_id), .sl_ctx_valid(sl_ctx_valid),
    .sl_ctx_id(sl_ctx_id), .sl_r_valid(sl_r_valid), .sl_r_ready(sl_r_ready),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .m_r_id(m_r_id), .m_r_last(m_r_last), .r_owner(r_owner), .r_busy(r_busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad   = 0;
  ar_t ar_q[$];
  int  r_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------- AR reference model / scoreboard -------------------------
  int unsigned mdl_ptr  = 0;
  bit          mdl_busy = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (!resetN) begin
      mdl_ptr  = 0;
      mdl_busy = 1'b0;
      ar_q.delete();
    end else if (en) begin
      if (!mdl_busy) begin
        logic [N-1:0] exp_rdy;
        int           w;
        exp_rdy = '0;
        w       = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && sl_ar_valid[(mdl_ptr + k) % N]) w = int'((mdl_ptr + k) % N);
        if (w >= 0) exp_rdy[w] = 1'b1;
        check("m_ar_valid_idle", 64'(m_ar_valid), 64'd0);
        check("sl_ar_ready", 64'(sl_ar_ready), 64'(exp_rdy));
        if (w >= 0) begin
          ar_q.push_back('{addr: addr_a[w], len: len_a[w], id: id_a[w]});
          mdl_ptr  = (w + 1) % N;
          mdl_busy = 1'b1;
        end
      end else begin
        check("sl_ar_ready_issue", 64'(sl_ar_ready), 64'd0);
        check("m_ar_valid_issue", 64'(m_ar_valid), 64'd1);
        if (m_ar_ready) begin
          if (ar_q.size() == 0) begin
            check("ar_unexpected", 64'd1, 64'd0);
          end else begin
            ar_t e;
            e = ar_q.pop_front();
            check("m_ar_addr", 64'(m_ar_addr), 64'(e.addr));
            check("m_ar_len", 64'(m_ar_len), 64'(e.len));
            check("m_ar_id", 64'(m_ar_id), 64'(e.id));
          end
          mdl_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- R beat scoreboard ----------------------------------------
  always begin
    @(negedge clk);
    #2;
    if (resetN && en && m_r_valid && m_r_ready) begin
      int act;
      act = -1;
      for (int i = 0; i < N; i++) if (sl_r_valid[i] && sl_r_ready[i]) act = i;
      if (r_q.size() == 0) check("r_beat_unexpected", 64'd1, 64'd0);
      else                 check("r_beat_dest", 64'(act), 64'(r_q.pop_front()));
    end
  end

  // Drives one R burst. dest < 0 means the burst must be dropped. sl_r_ready
  // is held low for the first 'stall' cycles (cycle 0 is the routing decision).
  // After 'clr_after' beats, the destination's context is withdrawn.
  task automatic burst(input logic [TW-1:0] id, input int beats, input int dest,
                       input int stall, input int clr_after);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    for (int b = 0; b < beats; b++) r_q.push_back(dest);
    m_r_id    = id;
    m_r_valid = 1'b1;
    while (got < beats && cyc < 50) begin
      m_r_last   = (got == beats - 1);
      sl_r_ready = (cyc < stall) ? '0 : '1;
      #1;
      if (cyc == 0) begin
        check("r_decide_ready", 64'(m_r_ready), 64'd0);
        check("r_decide_valid", 64'(sl_r_valid), 64'd0);
      end else if (dest < 0) begin
        check("drop_ready", 64'(m_r_ready), 64'd1);
        check("drop_no_valid", 64'(sl_r_valid), 64'd0);
        check("drop_busy", 64'(r_busy), 64'd1);
      end else begin
        check("route_valid", 64'(sl_r_valid), 64'(N'(1) << dest));
        check("route_ready", 64'(m_r_ready), 64'(cyc >= stall));
        check("route_owner", 64'(r_owner), 64'(dest));
        check("route_busy", 64'(r_busy), 64'd1);
      end
      if (m_r_ready) begin
        got++;
        if (got == clr_after) sl_ctx_valid[dest] = 1'b0;
      end
      cyc++;
      step();
    end
    if (cyc >= 50) check("r_burst_timeout", 64'd0, 64'd1);
    m_r_valid  = 1'b0;
    m_r_last   = 1'b0;
    sl_r_ready = '0;
    #1;
    check("r_busy_clear", 64'(r_busy), 64'd0);
    step();
  endtask

  int exp_order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (limit reached, expected completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    int g_idx [6];
    int g_cyc [6];
    int gcnt;

    resetN       = 1'b0;
    en           = 1'b1;
    sl_ar_valid  = '1;
    sl_ctx_valid = '0;
    sl_r_ready   = '0;
    m_ar_ready   = 1'b0;
    m_r_valid    = 1'b0;
    m_r_id       = '0;
    m_r_last     = 1'b0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = 64'h1000_0000 + 64'(i) * 64'h40;
      len_a[i]  = LW'(i + 1);
      id_a[i]   = TW'(8'h20 + i);
      ctx_a[i]  = TW'(8'h30 + i);
    end

    // Reset state (requests present but held off by reset).
    #2;
    check("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
    check("rst_m_ar_addr", 64'(m_ar_addr), 64'd0);
    check("rst_sl_ar_ready", 64'(sl_ar_ready), 64'd0);
    check("rst_m_r_ready", 64'(m_r_ready), 64'd0);
    check("rst_r_busy", 64'(r_busy), 64'd0);
    check("rst_r_owner", 64'(r_owner), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    sl_ar_valid = '0;
    step();
    step();
    resetN = 1'b1;
    step();

    // Fairness: all slices request continuously, master always ready.
    sl_ar_valid = '1;
    m_ar_ready  = 1'b1;
    gcnt        = 0;
    for (int c = 0; c < 20 && gcnt < 6; c++) begin
      #1;
      if (|sl_ar_ready) begin
        g_idx[gcnt] = -1;
        for (int i = 0; i < N; i++) if (sl_ar_ready[i]) g_idx[gcnt] = i;
        g_cyc[gcnt] = c;
        gcnt++;
      end
      step();
    end
    sl_ar_valid = '0;
    check("fair_grant_count", 64'(gcnt), 64'd6);
    for (int i = 0; i < 6; i++) check($sformatf("fair_order_%0d", i), 64'(g_idx[i]), 64'(exp_order[i]));
    for (int i = 1; i < 6; i++) check($sformatf("fair_spacing_%0d", i), 64'(g_cyc[i] - g_cyc[i-1]), 64'd2);
    step();
    step();
    m_ar_ready = 1'b0;
    check("fair_ar_q_empty", 64'(ar_q.size()), 64'd0);

    // Single request from slice 2 with master backpressure.
    addr_a[2]   = 64'h1000;
    len_a[2]    = 8'd3;
    id_a[2]     = 8'd5;
    sl_ar_valid = 4'b0100;
    #1;
    check("single_grant", 64'(sl_ar_ready), 64'b0100);
    step();
    sl_ar_valid = '0;
    #1;
    check("single_valid", 64'(m_ar_valid), 64'd1);
    check("single_addr", 64'(m_ar_addr), 64'h1000);
    check("single_len", 64'(m_ar_len), 64'd3);
    check("single_id", 64'(m_ar_id), 64'd5);
    for (int c = 0; c < 3; c++) begin
      step();
      // Slice 3 pulses valid while the bus is busy and withdraws it: skipped.
      sl_ar_valid = (c == 0) ? 4'b1000 : 4'b0000;
      #1;
      check("hold_valid", 64'(m_ar_valid), 64'd1);
      check("hold_addr", 64'(m_ar_addr), 64'h1000);
      check("hold_no_grant", 64'(sl_ar_ready), 64'd0);
    end
    m_ar_ready = 1'b1;
    step();
    m_ar_ready = 1'b0;
    #1;
    check("single_valid_drop", 64'(m_ar_valid), 64'd0);
    step();

    // Routing with backpressure; slice 0 requests AR concurrently.
    ctx_a[0]     = 8'd7;
    ctx_a[1]     = 8'd7;
    sl_ctx_valid = 4'b0010;
    sl_ar_valid  = 4'b0001;
    m_ar_ready   = 1'b1;
    burst(8'd7, 4, 1, 3, -1);
    sl_ar_valid = '0;
    step();
    step();
    m_ar_ready = 1'b0;

    // Mid-burst context withdrawal: beats 3-4 still go to slice 1.
    sl_ctx_valid = 4'b0010;
    burst(8'd7, 4, 1, 0, 2);
    check("ctx_cleared", 64'(sl_ctx_valid), 64'd0);

    // Lowest matching slice wins when two contexts match.
    ctx_a[2]     = 8'd7;
    sl_ctx_valid = 4'b0110;
    burst(8'd7, 1, 1, 0, -1);

    // Unmatched burst is sunk.
    sl_ctx_valid = 4'b0010;
    burst(8'd9, 3, -1, 0, -1);
`ifdef PR_ARB_DROP_CNT_EN
    check("drop_cnt", 64'(drop_cnt), 64'd3);
`else
    check("drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    check("r_q_empty", 64'(r_q.size()), 64'd0);

    // Global enable low: nothing handshakes, FSMs hold.
    en          = 1'b0;
    sl_ar_valid = '1;
    m_r_valid   = 1'b1;
    m_r_id      = 8'd7;
    sl_r_ready  = '1;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("en_ar_ready", 64'(sl_ar_ready), 64'd0);
      check("en_m_r_ready", 64'(m_r_ready), 64'd0);
      check("en_sl_r_valid", 64'(sl_r_valid), 64'd0);
      check("en_m_ar_valid", 64'(m_ar_valid), 64'd0);
      check("en_r_busy", 64'(r_busy), 64'd0);
      step();
    end
    sl_ar_valid = '0;
    m_r_valid   = 1'b0;
    sl_r_ready  = '0;
    en          = 1'b1;
    step();

    // Asynchronous reset during AR_ISSUE and R_ROUTE.
    sl_ar_valid = 4'b0100;
    m_ar_ready  = 1'b0;
    step();
    sl_ar_valid = '0;
    m_r_id      = 8'd7;
    m_r_valid   = 1'b1;
    step();
    step();
    #1;
    check("pre_rst_route", 64'(sl_r_valid), 64'b0010);
    check("pre_rst_ar_valid", 64'(m_ar_valid), 64'd1);
    #2;
    resetN      = 1'b0;
    sl_ar_valid = 4'b1010;
    #1;
    check("arst_m_ar_valid", 64'(m_ar_valid), 64'd0);
    check("arst_m_r_ready", 64'(m_r_ready), 64'd0);
    check("arst_sl_r_valid", 64'(sl_r_valid), 64'd0);
    check("arst_r_busy", 64'(r_busy), 64'd0);
    check("arst_sl_ar_ready", 64'(sl_ar_ready), 64'd0);
    m_r_valid = 1'b0;
    step();
    step();
    resetN = 1'b1;
    #1;
    check("post_rst_grant", 64'(sl_ar_ready), 64'b0010);
    step();
    sl_ar_valid = '0;
    m_ar_ready  = 1'b1;
    step();
    step();
    m_ar_ready = 1'b0;
    check("final_ar_q_empty", 64'(ar_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prefetch_slice_arbiter.md
Name: prefetch_slice_arbiter

Overview:
- Shares one master AXI read port (AR + R) toward DDR between NUM_SLICES prefetcher slice controllers.
- AR channel: round-robin arbitration, one request in flight on the AR bus at a time.
- R channel: each burst is steered to the slice whose context ID matches the returning ID, locked for the whole burst.
- Sits between the per-slice prefetch controllers and the DDR AXI master.

Parameters:
- NUM_SLICES, 4, number of requesting slices (2..16).
- ADDR_BITS, 64, AR address width.
- BURST_LEN_WIDTH, 8, AR len width.
- TID_WIDTH, 8, AXI ID width.
- DROP_CNT_WIDTH, 16, unmatched-beat counter width.
- Derived localparam: IDX_W = max(1, $clog2(NUM_SLICES)).

Ports:
- clk  in  1  clock.
- resetN  in  1  asynchronous reset, active-low.
- en  in  1  global enable; when low, all registers hold and no handshake completes.
- sl_ar_valid  in  NUM_SLICES  per-slice read request valid.
- sl_ar_ready  out  NUM_SLICES  per-slice grant/accept, combinational.
- sl_ar_addr  in  NUM_SLICES*ADDR_BITS  flattened; slice i at bits [i*ADDR_BITS +: ADDR_BITS].
- sl_ar_len  in  NUM_SLICES*BURST_LEN_WIDTH  flattened.
- sl_ar_id  in  NUM_SLICES*TID_WIDTH  flattened.
- sl_ctx_valid  in  NUM_SLICES  slice has a learned context (ID is meaningful).
- sl_ctx_id  in  NUM_SLICES*TID_WIDTH  slice context ID used for R routing.
- sl_r_valid  out  NUM_SLICES  per-slice read data valid.
- sl_r_ready  in  NUM_SLICES  per-slice read data ready.
- m_ar_valid  out  1  registered.
- m_ar_ready  in  1.
- m_ar_addr  out  ADDR_BITS  registered.
- m_ar_len  out  BURST_LEN_WIDTH  registered.
- m_ar_id  out  TID_WIDTH  registered.
- m_r_valid  in  1.
- m_r_ready  out  1  combinational.
- m_r_id  in  TID_WIDTH.
- m_r_last  in  1.
- r_owner  out  IDX_W  index of the slice currently owning R; valid while r_busy is high.
- r_busy  out  1  R channel locked to a slice or to drop.
- drop_cnt  out  DROP_CNT_WIDTH  saturating count of unmatched R beats (see Optional Feature).

Behaviour:
- Reset values: m_ar_valid=0, m_ar_addr/len/id=0, rr_ptr=0, AR FSM=AR_IDLE, R FSM=R_IDLE, r_owner=0, r_busy=0, drop_cnt=0. sl_ar_ready, sl_r_valid and m_r_ready are all 0 while reset is asserted.
- AR FSM AR_IDLE:
  - Winner = first i with sl_ar_valid[i], searching from rr_ptr upward and wrapping modulo NUM_SLICES.
  - sl_ar_ready[winner]=1 combinationally in the same cycle; all other bits are 0.
  - On that handshake (and en=1): capture addr/len/id into m_ar_*, set m_ar_valid=1, rr_ptr=(winner+1) mod NUM_SLICES, go to AR_ISSUE.
  - m_ar_valid therefore rises 1 cycle after the slice handshake.
- AR FSM AR_ISSUE:
  - sl_ar_ready is all 0.
  - m_ar_valid and payload are held stable until m_ar_ready=1.
  - On m_ar_valid & m_ar_ready: m_ar_valid=0 next cycle, go to AR_IDLE.
  - Minimum spacing is 2 cycles between slice grants.
- R FSM R_IDLE:
  - m_r_ready=0, sl_r_valid=0.
  - On m_r_valid: find the lowest i with sl_ctx_valid[i] & sl_ctx_id[i]==m_r_id.
  - Match: r_owner=i, r_busy=1, go to R_ROUTE.
  - No match: r_busy=1, go to R_DROP.
  - The first beat is not consumed in the decision cycle (1-cycle routing latency).
- R FSM R_ROUTE:
  - sl_r_valid[r_owner]=m_r_valid; m_r_ready=sl_r_ready[r_owner]; other slices see 0.
  - On handshake with m_r_last=1: r_busy=0, go to R_IDLE.
- R FSM R_DROP:
  - m_r_ready=1; each accepted beat increments drop_cnt (saturates at all-ones).
  - On a last beat: go to R_IDLE.
- Ownership lock: while in R_ROUTE, changes to sl_ctx_valid/sl_ctx_id do not move ownership. A slice flushing mid-burst still receives the rest of its burst.
- AR and R FSMs are independent; simultaneous AR grant and R beat are both allowed in the same cycle.
- A slice that drops sl_ar_valid before grant is simply skipped; no grant is issued to it.
- Asynchronous reset mid-burst: everything returns to the reset values immediately. Any in-flight DDR burst then arrives in R_IDLE and is routed or dropped by its ID.
- en=0: no ready/valid toward any side is asserted, and FSM and pointer hold.

Optional Feature:
- Macro PR_ARB_DROP_CNT_EN.
- Defined: R_DROP counts as described; drop_cnt is live.
- Undefined: drop_cnt is tied to 0 and no counter register is built. R_DROP still sinks the unmatched beats with m_r_ready=1.

Test Plan:
- Single request: slice2 asserts valid with addr=0x1000, len=3, id=5 -> sl_ar_ready=0b0100 in the same cycle; next cycle m_ar_valid=1, m_ar_addr=0x1000, m_ar_len=3, m_ar_id=5; m_ar_ready held 0 for 3 cycles -> payload stable, then m_ar_valid drops 1 cycle after the handshake.
- Fairness: all 4 slices request continuously with m_ar_ready=1 -> grant order 0,1,2,3,0,1; a new grant every 2 cycles.
- Routing: sl_ctx_id[1]=7, sl_ctx_valid=0b0010; 4-beat burst with m_r_id=7 and last on beat 4 -> only sl_r_valid[1] toggles, r_owner=1; sl_r_ready[1] low for 2 cycles backpressures m_r_ready; r_busy clears after the last beat.
- Unmatched: burst of 3 beats with m_r_id=9 and no matching context -> m_r_ready=1 throughout, no sl_r_valid asserted, drop_cnt=3. With the macro undefined -> drop_cnt=0.
- Mid-burst context change: clear sl_ctx_valid[1] after beat 2 of a 4-beat burst -> beats 3-4 still go to slice 1.
- Reset: assert resetN=0 during AR_ISSUE and R_ROUTE -> m_ar_valid, m_r_ready, sl_r_valid and r_busy all go 0 asynchronously; after release the first request is granted starting from rr_ptr=0.
